// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer for the EX stage: registered multiplier plus
// radix-2 restoring divider. It stalls the pipeline while busy and pulses Done for one cycle.
module muldiv_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            MDBusyE,
  output logic            MDDoneE,
  output logic [XLEN-1:0] MDResultE
);

  localparam int unsigned CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] counter, counterNext;
  logic [XLEN-1:0]  resultNext;
  logic             loadOps, divStep;

  logic [XLEN-1:0]  opA, opB, quo, rem;
  logic [1:0]       fnReg;
  logic             negQ, negR;

  // Operand qualification at capture time
  logic            startOk, inSigned, aNegIn, bNegIn, bZero, divOvf;
  logic [XLEN-1:0] absA, absB, specialRes;

  assign startOk  = (state == IDLE) & StartE & ~FlushE;
  assign inSigned = ~funct3E[0];
  assign aNegIn   = inSigned & SrcAE[XLEN-1];
  assign bNegIn   = inSigned & SrcBE[XLEN-1];
  assign absA     = aNegIn ? -SrcAE : SrcAE;
  assign absB     = bNegIn ? -SrcBE : SrcBE;
  assign bZero    = (SrcBE == '0);
  assign divOvf   = inSigned & (SrcAE == MIN_NEG) & (SrcBE == '1);

  // Divide-by-zero and signed-overflow results, resolved without iterating
  always_comb begin
    specialRes = SrcAE;
    if (bZero) specialRes = funct3E[1] ? SrcAE : '1;
    else       specialRes = funct3E[1] ? '0 : SrcAE;
  end

  // Multiplier: live operands when finishing straight from IDLE, captured ones otherwise
  logic [1:0]        mulFn;
  logic [XLEN-1:0]   mulA, mulB, mulRes;
  logic              mulSignA, mulSignB;
  logic [2*XLEN-1:0] aWide, bWide, product;

  assign mulFn    = (state == IDLE) ? funct3E[1:0] : fnReg;
  assign mulA     = (state == IDLE) ? SrcAE : opA;
  assign mulB     = (state == IDLE) ? SrcBE : opB;
  assign mulSignA = (mulFn == 2'b01) | (mulFn == 2'b10);
  assign mulSignB = (mulFn == 2'b01);
  assign aWide    = {{XLEN{mulSignA & mulA[XLEN-1]}}, mulA};
  assign bWide    = {{XLEN{mulSignB & mulB[XLEN-1]}}, mulB};
  assign product  = aWide * bWide;
  assign mulRes   = (mulFn == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // One restoring-division step, with sign fix for the final iteration
  logic [XLEN:0]   remShift;
  logic [XLEN-1:0] remSub, remStep, quoStep, divRes;
  logic            geq;

  assign remShift = {rem, quo[XLEN-1]};
  assign geq      = (remShift >= {1'b0, opB});
  assign remSub   = XLEN'(remShift - {1'b0, opB});
  assign remStep  = geq ? remSub : remShift[XLEN-1:0];
  assign quoStep  = {quo[XLEN-2:0], geq};
  assign divRes   = fnReg[1] ? (negR ? -remStep : remStep)
                             : (negQ ? -quoStep : quoStep);

  // Next-state, counter and result selection
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    resultNext  = MDResultE;
    loadOps     = 1'b0;
    divStep     = 1'b0;
    case (state)
      IDLE: begin
        if (startOk) begin
          loadOps = 1'b1;
          if (!funct3E[2]) begin
            if (MUL_LAT == 1) begin
              stateNext  = DONE;
              resultNext = mulRes;
            end else begin
              stateNext   = MUL;
              counterNext = CNT_W'(MUL_LAT - 1);
            end
          end else if (bZero || divOvf) begin
            stateNext  = DONE;
            resultNext = specialRes;
          end else begin
            stateNext   = DIV;
            counterNext = CNT_W'(XLEN);
          end
        end
      end
      MUL: begin
        counterNext = counter - 1'b1;
        if (counterNext == '0) begin
          stateNext  = DONE;
          resultNext = mulRes;
        end
      end
      DIV: begin
        divStep     = 1'b1;
        counterNext = counter - 1'b1;
        if (counterNext == '0) begin
          stateNext  = DONE;
          resultNext = divRes;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (FlushE) begin
      stateNext   = IDLE;
      counterNext = '0;
      resultNext  = MDResultE;
      loadOps     = 1'b0;
      divStep     = 1'b0;
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      MDResultE <= '0;
    end else begin
      state     <= stateNext;
      counter   <= counterNext;
      MDResultE <= resultNext;
    end
  end

  // Operand capture and divider working registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opA   <= '0;
      opB   <= '0;
      quo   <= '0;
      rem   <= '0;
      fnReg <= '0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
    end else if (loadOps) begin
      opA   <= SrcAE;
      opB   <= funct3E[2] ? absB : SrcBE;
      quo   <= absA;
      rem   <= '0;
      fnReg <= funct3E[1:0];
      negQ  <= aNegIn ^ bNegIn;
      negR  <= aNegIn;
    end else if (divStep) begin
      quo <= quoStep;
      rem <= remStep;
    end
  end

  // Stall while accepting or running; Done only from the DONE state
  assign MDBusyE = reset_n & ~FlushE &
                   (((state == IDLE) & StartE) | (state == MUL) | (state == DIV));
  assign MDDoneE = (state == DONE) & ~FlushE;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN=32, MUL_LAT=2): vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_seq;

  logic        clk;
  logic        reset_n;
  logic        StartE;
  logic        FlushE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        MDBusyE;
  logic        MDDoneE;
  logic [31:0] MDResultE;

  muldiv_seq #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .StartE    (StartE),
    .FlushE    (FlushE),
    .funct3E   (funct3E),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .MDBusyE   (MDBusyE),
    .MDDoneE   (MDDoneE),
    .MDResultE (MDResultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          doneCyc;
  } vecT;

  localparam int NV = 20;
  vecT vecs [NV];

  int checks = 0;
  int errors = 0;
  logic [31:0] lastRes = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle 0 at entry (posedge+3 or later); returns at posedge+3 of the cycle after Done
  task automatic runOp(input int id, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int doneCyc);
    int cyc;
    int busyBad;
    StartE = 1'b1; funct3E = fn; SrcAE = a; SrcBE = b;
    #2;
    chk($sformatf("v%0d busy_c0", id), 32'(MDBusyE), 32'd1);
    @(posedge clk); #1;
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom; funct3E = 3'($urandom_range(7));
    #2;
    cyc = 1; busyBad = 0;
    while (MDDoneE !== 1'b1 && cyc < 60) begin
      if (MDBusyE !== 1'b1) busyBad++;
      @(posedge clk); #3;
      cyc++;
    end
    chk($sformatf("v%0d done_cycle", id), 32'(cyc), 32'(doneCyc));
    chk($sformatf("v%0d busy_gaps", id), 32'(busyBad), 32'd0);
    chk($sformatf("v%0d result", id), MDResultE, res);
    chk($sformatf("v%0d busy_at_done", id), 32'(MDBusyE), 32'd0);
    @(posedge clk); #3;
    chk($sformatf("v%0d done_pulse_end", id), 32'(MDDoneE), 32'd0);
    chk($sformatf("v%0d result_held", id), MDResultE, res);
    lastRes = res;
  endtask

  initial begin
    int doneSeen;
    reset_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; funct3E = 3'b000; SrcAE = '0; SrcBE = '0;

    vecs[0]  = '{F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[2]  = '{F_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[3]  = '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[4]  = '{F_DIV,    32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{F_REM,    32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 33};
    vecs[6]  = '{F_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{F_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{F_REM,    32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[13] = '{F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[14] = '{F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33};
    vecs[15] = '{F_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[16] = '{F_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1};
    vecs[17] = '{F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[18] = '{F_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 2};
    vecs[19] = '{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(MDBusyE), 32'd0);
    chk("reset_done", 32'(MDDoneE), 32'd0);
    chk("reset_result", MDResultE, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #3;
    chk("idle_busy", 32'(MDBusyE), 32'd0);

    for (int i = 0; i < NV; i++)
      runOp(i, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].doneCyc);

    // Flush a DIV at cycle 10, then a MUL at cycle 11
    StartE = 1'b1; funct3E = F_DIVU; SrcAE = 32'd1000; SrcBE = 32'd3;
    @(posedge clk); #1;
    StartE = 1'b0;
    doneSeen = 0;
    for (int c = 1; c < 10; c++) begin
      #2;
      if (MDDoneE === 1'b1) doneSeen++;
      @(posedge clk); #1;
    end
    FlushE = 1'b1;
    #2;
    chk("flush_busy_c10", 32'(MDBusyE), 32'd0);
    chk("flush_done_c10", 32'(MDDoneE), 32'd0);
    chk("flush_no_early_done", 32'(doneSeen), 32'd0);
    @(posedge clk); #1;
    FlushE = 1'b0;
    #2;
    chk("flush_idle_busy_c11", 32'(MDBusyE), 32'd0);
    chk("flush_idle_done_c11", 32'(MDDoneE), 32'd0);
    chk("flush_result_kept", MDResultE, lastRes);
    runOp(100, F_MUL, 32'd3, 32'd5, 32'd15, 2);

    // Reset asserted at cycle 5 of a DIV
    StartE = 1'b1; funct3E = F_REM; SrcAE = 32'hFFFF_FFEC; SrcBE = 32'd6;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2;
    chk("rst_mid_busy_before", 32'(MDBusyE), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(MDBusyE), 32'd0);
    chk("rst_mid_done", 32'(MDDoneE), 32'd0);
    chk("rst_mid_result", MDResultE, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #3;
      if (MDDoneE === 1'b1) doneSeen++;
    end
    chk("rst_no_done", 32'(doneSeen), 32'd0);
    chk("rst_result_stays0", MDResultE, 32'd0);

    // Back-to-back MULs with StartE held high through DONE
    StartE = 1'b1; funct3E = F_MUL; SrcAE = 32'd6; SrcBE = 32'd7;
    #2;
    chk("b2b_busy_c0", 32'(MDBusyE), 32'd1);
    @(posedge clk); #1;
    SrcAE = 32'h1234_5678; SrcBE = 32'h9ABC_DEF0;
    #2;
    chk("b2b_busy_c1", 32'(MDBusyE), 32'd1);
    chk("b2b_done_c1", 32'(MDDoneE), 32'd0);
    @(posedge clk); #1;
    SrcAE = 32'hFFFF_FFFC; SrcBE = 32'd5;
    #2;
    chk("b2b_done_c2", 32'(MDDoneE), 32'd1);
    chk("b2b_result_c2", MDResultE, 32'd42);
    chk("b2b_busy_c2", 32'(MDBusyE), 32'd0);
    @(posedge clk); #3;
    chk("b2b_done_c3", 32'(MDDoneE), 32'd0);
    chk("b2b_busy_c3", 32'(MDBusyE), 32'd1);
    chk("b2b_result_c3", MDResultE, 32'd42);
    @(posedge clk); #1;
    StartE = 1'b0;
    #2;
    chk("b2b_busy_c4", 32'(MDBusyE), 32'd1);
    chk("b2b_done_c4", 32'(MDDoneE), 32'd0);
    @(posedge clk); #3;
    chk("b2b_done_c5", 32'(MDDoneE), 32'd1);
    chk("b2b_result_c5", MDResultE, 32'hFFFF_FFEC);
    @(posedge clk); #3;
    chk("b2b_done_c6", 32'(MDDoneE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
